// File: rtl/dram_rd_model.sv
// Memory-side response model for the DRAM cache controller.
// It returns in-order reads after a fixed latency and applies paired AW/W line writes.
module dram_rd_model #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned ID_W    = 16,
  parameter int unsigned TAG_S   = 64,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned IDX_LSB = 6,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_W-1:0]         ar_id_i,
  input  logic [ADDR_W-1:0]       ar_addr_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic [ID_W-1:0]         r_id_o,
  output logic [TAG_S+DATA_W-1:0] r_data_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  input  logic [ADDR_W-1:0]       aw_addr_i,
  input  logic                    aw_valid_i,
  output logic                    aw_ready_o,
  input  logic [TAG_S+DATA_W-1:0] w_data_i,
  input  logic                    w_valid_i,
  output logic                    w_ready_o
);

  localparam int unsigned LINE_W = TAG_S + DATA_W;
  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned TMR_W  = $clog2(LATENCY + 1);

  logic [LINE_W-1:0]  mem [LINES];
  logic [LINES-1:0]   written;
  logic [LINE_W-1:0]  q_data [DEPTH];
  logic [ID_W-1:0]    q_id [DEPTH];
  logic [TMR_W-1:0]   q_tmr [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, head_n;
  logic [CNT_W-1:0]   count, cnt_n;
  logic [INDEX_W-1:0] ar_idx, aw_idx;
  logic [LINE_W-1:0]  snap;
  logic [TMR_W-1:0]   head_tmr_n;
  logic               push, pop, wr_en;
  logic               valid_n;
  logic [ID_W-1:0]    id_n;
  logic [LINE_W-1:0]  data_n;

  // Address bits outside the index field are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ar_addr_i, aw_addr_i};

  assign ar_idx     = ar_addr_i[IDX_LSB +: INDEX_W];
  assign aw_idx     = aw_addr_i[IDX_LSB +: INDEX_W];
  assign wr_en      = aw_valid_i && w_valid_i;
  assign aw_ready_o = rst_n && wr_en;
  assign w_ready_o  = rst_n && wr_en;
  assign push       = ar_valid_i && ar_ready_o;
  assign pop        = r_valid_o && r_ready_i;
  assign snap       = written[ar_idx] ? mem[ar_idx] : '0;

  // Next-cycle view of the FIFO head, so the R channel can be registered.
  always_comb begin
    cnt_n   = count;
    valid_n = 1'b0;
    id_n    = '0;
    data_n  = '0;
    if (push && !pop) begin
      cnt_n = count + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_n = count - CNT_W'(1);
    end
    head_n     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    head_tmr_n = (q_tmr[head_n] >= TMR_W'(LATENCY)) ? TMR_W'(LATENCY)
                                                   : q_tmr[head_n] + TMR_W'(1);
    if (cnt_n != '0) begin
      if (push && (wr_ptr == head_n)) begin
        // The entry being pushed becomes the head of an otherwise empty queue.
        if (LATENCY == 1) begin
          valid_n = 1'b1;
          id_n    = ar_id_i;
          data_n  = snap;
        end
      end else if (head_tmr_n >= TMR_W'(LATENCY)) begin
        valid_n = 1'b1;
        id_n    = q_id[head_n];
        data_n  = q_data[head_n];
      end
    end
  end

  // Control state and registered R channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      written    <= '0;
      ar_ready_o <= 1'b1;
      r_valid_o  <= 1'b0;
      r_id_o     <= '0;
      r_data_o   <= '0;
    end else begin
      count      <= cnt_n;
      rd_ptr     <= head_n;
      ar_ready_o <= (cnt_n < CNT_W'(DEPTH));
      r_valid_o  <= valid_n;
      r_id_o     <= id_n;
      r_data_o   <= data_n;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (wr_en) begin
        written[aw_idx] <= 1'b1;
      end
    end
  end

  // Queue payload and latency timers; timers saturate at LATENCY.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (q_tmr[i] < TMR_W'(LATENCY)) begin
        q_tmr[i] <= q_tmr[i] + TMR_W'(1);
      end
    end
    if (rst_n && push) begin
      q_tmr[wr_ptr]  <= TMR_W'(1);
      q_id[wr_ptr]   <= ar_id_i;
      q_data[wr_ptr] <= snap;
    end
  end

  // Line storage is not cleared by reset; the written bits mask stale content.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[aw_idx] <= w_data_i;
    end
  end

endmodule

// File: doc/dram_rd_model.md
# dram_rd_model

Parametrised, synthesizable memory-controller response model for the DRAM cache controller's memory-side (`m_`) AR/R/AW/W ports. It holds a tag+data line per set, accepts up to DEPTH outstanding reads and returns them in order after a programmable latency, and applies line writes. It replaces hand-driven `m_arready_i`/`m_rvalid_i` stimulus in top-level benches, and can stand in for the memory controller in FPGA bring-up.

## Interface
- ADDR_W, 64, address width
- ID_W, 16, transaction ID width
- TAG_S, 64, tag/metadata field width stored above each data line
- DATA_W, 512, data line width
- INDEX_W, 10, set-index width (2^INDEX_W lines)
- IDX_LSB, 6, LSB position of the index field in the address
- DEPTH, 8, maximum outstanding reads (≥2, power of two)
- LATENCY, 4, accept-to-response cycles (≥1)

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ar_id_i  in  ID_W  read ID
- ar_addr_i  in  ADDR_W  read address
- ar_valid_i  in  1  read request valid
- ar_ready_o  out  1  read request accepted
- r_id_o  out  ID_W  response ID
- r_data_o  out  TAG_S+DATA_W  {tag field, data line}
- r_valid_o  out  1  response valid
- r_ready_i  in  1  response consumed
- aw_addr_i  in  ADDR_W  write address
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address accepted
- w_data_i  in  TAG_S+DATA_W  line written (tag+data)
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data accepted

## Operation
- Index = addr[IDX_LSB +: INDEX_W]; other address bits are ignored.
- Storage: line array plus per-line written bit. Reset clears all written bits; lines are not cleared. A read of an unwritten line returns all zeros.
- Read accept: `ar_ready_o = (count < DEPTH)`, with count the registered outstanding count. At full, no accept occurs even if a pop happens in the same cycle.
- On accept, the line is snapshotted into the FIFO entry with its ID and a latency timer. Later writes do not alter a queued response.
- Responses are strictly in order. The head entry presents `r_valid_o` once its timer reaches LATENCY. The entry pops on `r_valid_o && r_ready_i`.
- Write: AW and W are paired. `aw_ready_o = w_ready_o = aw_valid_i && w_valid_i`. The line and written bit update at the edge when both are valid. A lone AW or W waits and is not accepted.
- Same-cycle read accept and write to the same index: the read snapshots the pre-write content.
- count: +1 on accept, −1 on pop; both in one cycle leaves count unchanged.

## Timing
- Reset (rst_n low at an edge): `ar_ready_o` 1 after reset, `r_valid_o` 0, `r_id_o` 0, `r_data_o` 0, count 0, FIFO pointers 0, written bits cleared.
- Reset mid-operation drops all outstanding reads with no response. `aw_ready_o`/`w_ready_o` are forced 0 while rst_n is low.
- Latency: AR handshake in cycle t → `r_valid_o` first high in cycle t+LATENCY.
- Timers keep counting while the head is stalled. After a stalled head pops, an already-matured next entry is valid in the very next cycle.
- Throughput: 1 response/cycle with `r_ready_i` held high; back-to-back accepts return back-to-back.
- `r_valid_o`, `r_id_o` and `r_data_o` are stable while `r_valid_o && !r_ready_i`.
- Pointers wrap modulo DEPTH; count saturates at neither end (over/underflow impossible by construction).

## Test plan
- Reset, then AR addr 0xabcd1234abcd1234, id 3, no prior write → accept cycle t; `r_valid_o` in t+4; `r_id_o`=3; `r_data_o`=0.
- Write AW addr 0xabcd1234abcd1234 (index 0x048) with w_data {tag 0xabcd<<48, data 0xaaaabbbb}, then read the same address → `r_data_o` equals the written line exactly, LATENCY cycles after accept.
- With `r_ready_i`=0, issue 8 reads with ids 0..7 → 8 accepts, then `ar_ready_o`=0. Raise `r_ready_i` → ids 0..7 in order on 8 consecutive cycles; `ar_ready_o` returns 1 the cycle after the first pop.
- Same cycle: write 0x55.. to index 0x10 and AR to index 0x10 (line previously 0x11..) → the response carries 0x11..; a subsequent read returns 0x55...
- AW valid without W for 5 cycles → `aw_ready_o`=0 throughout, storage unchanged. Assert W → both readies 1 for that cycle and the write lands.
- Three reads outstanding, then assert reset for 1 cycle → no `r_valid_o` afterwards, `ar_ready_o`=1, and the previously written line reads back as 0.
